// File: rtl/gpio_button_decode_if.sv
// Button decode port bundle: synchronised GPIO level in, debounced level and press pulses out.
// master drives the pin level and observes the decode; slave is the decoder.
interface gpio_button_decode_if;
  logic i_sync;
  logic o_level;
  logic o_rise;
  logic o_fall;
  logic o_short;
  logic o_long;
  logic o_held;

  modport master (
    output i_sync,
    input  o_level, o_rise, o_fall, o_short, o_long, o_held
  );

  modport slave (
    input  i_sync,
    output o_level, o_rise, o_fall, o_short, o_long, o_held
  );
endinterface

// File: rtl/gpio_button_decode.sv
// Debounces one synchronised GPIO level, emits edge pulses and classifies presses as short/long.
// Every output is a flop; a debounced change appears DEBOUNCE_CYCLES edges after the input settles.
module gpio_button_decode #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int LONG_CYCLES     = 6000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  gpio_button_decode_if.slave  btn
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  logic          raw;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [HW-1:0] hold_q, hold_d;
  state_e        state_q, state_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          held_q, held_d;

  assign raw = btn.i_sync ^ ACTIVE_LOW;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (raw == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = raw;
      deb_cnt_d = '0;
      rise_d    = raw;
      fall_d    = ~raw;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  // hold_q reads 0 in the o_rise cycle and k in cycle T+k, so hitting
  // LONG_CYCLES-1 at T+LONG_CYCLES-1 lands o_long exactly at T+LONG_CYCLES.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    if (rise_d) begin
      hold_d = '0;
    end else if (rise_q || state_q == PRESSED) begin
      hold_d = hold_q + HW'(1);
    end
    case (state_q)
      IDLE: begin
        if (rise_q) state_d = PRESSED;
      end
      PRESSED: begin
        if (!level_q) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (!level_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == LONG);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      hold_q    <= '0;
      state_q   <= IDLE;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      short_q   <= short_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign btn.o_level = level_q;
  assign btn.o_rise  = rise_q;
  assign btn.o_fall  = fall_q;
  assign btn.o_short = short_q;
  assign btn.o_long  = long_q;
  assign btn.o_held  = held_q;

endmodule

// File: tb/tb_gpio_button_decode.sv
// Scoreboarded bench for gpio_button_decode: expected output events are queued as stimulus is
// driven and matched, by cycle and value, whenever the DUT outputs change or pulse.
module tb_gpio_button_decode;

  localparam int DB = 4;
  localparam int LC = 20;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   al_phase = 1'b0;
  bit   al_bad = 1'b0;
  logic [5:0] prev = '0;
  ev_t  sb[$];

  gpio_button_decode_if bus ();
  gpio_button_decode_if bus_al ();

  gpio_button_decode #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .btn   (bus)
  );

  gpio_button_decode #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)) u_dut_al (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .btn   (bus_al)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Event vector layout: {level, held, rise, fall, short, long}
  function automatic logic [5:0] outs0();
    return {bus.o_level, bus.o_held, bus.o_rise, bus.o_fall, bus.o_short, bus.o_long};
  endfunction

  function automatic logic [5:0] outs_al();
    return {bus_al.o_level, bus_al.o_held, bus_al.o_rise, bus_al.o_fall, bus_al.o_short, bus_al.o_long};
  endfunction

  function automatic void push(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    logic [5:0] v;
    v = outs0();
    if (mon_en && (v[3:0] != 4'b0 || v[5:4] != prev[5:4])) begin
      if (sb.size() == 0) begin
        chk("sb_spurious", sb.size(), 1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cyc", cyc, e.cyc);
        chk("ev_vec", {26'b0, v}, {26'b0, e.vec});
      end
    end
    prev = v;
  end

  always @(negedge i_clk) begin
    if (mon_en && !al_phase && outs_al() !== 6'b0) al_bad = 1'b1;
  end

  // Press with release driven n cycles after the expected o_rise cycle T.
  task automatic do_press(input int n);
    int t, f;
    bus.i_sync = 1'b1;
    t = cyc + DB;
    f = t + n + DB;
    push(t, 6'b101000);
    if (f < t + LC) begin
      push(f, 6'b000100);
      push(f + 1, 6'b000010);
    end else if (f == t + LC) begin
      push(f, 6'b010101);
      push(f + 1, 6'b000000);
    end else begin
      push(t + LC, 6'b110001);
      push(f, 6'b010100);
      push(f + 1, 6'b000000);
    end
    tick(DB + n);
    bus.i_sync = 1'b0;
    tick(DB + 4);
    chk("press_drain", sb.size(), 0);
  endtask

  initial begin
    int t, r, f;
    i_rst = 1'b1;
    bus.i_sync = 1'b0;
    bus_al.i_sync = 1'b1;
    tick(3);
    chk("rst_dut0", {26'b0, outs0()}, 0);
    chk("rst_dut1", {26'b0, outs_al()}, 0);
    i_rst = 1'b0;
    mon_en = 1'b1;
    tick(5);
    chk("idle_level", bus.o_level, 0);

    do_press(12);

    repeat (10) begin
      bus.i_sync = 1'b1;
      tick(3);
      bus.i_sync = 1'b0;
      tick(1);
    end
    tick(6);
    chk("bounce_drain", sb.size(), 0);
    chk("bounce_level", bus.o_level, 0);

    do_press(40);
    do_press(15);
    do_press(16);

    bus.i_sync = 1'b1;
    t = cyc + DB;
    push(t, 6'b101000);
    push(t + LC, 6'b110001);
    tick(DB + LC + 5);
    chk("pre_rst_held", bus.o_held, 1);
    r = cyc;
    i_rst = 1'b1;
    push(r + 1, 6'b000000);
    tick(1);
    chk("rst_mid_a", {26'b0, outs0()}, 0);
    tick(1);
    chk("rst_mid_b", {26'b0, outs0()}, 0);
    i_rst = 1'b0;
    t = cyc + DB;
    push(t, 6'b101000);
    push(t + LC, 6'b110001);
    tick(DB + 30);
    bus.i_sync = 1'b0;
    f = cyc + DB;
    push(f, 6'b010100);
    push(f + 1, 6'b000000);
    tick(DB + 4);
    chk("rst_drain", sb.size(), 0);

    al_phase = 1'b1;
    chk("al_idle", al_bad, 0);
    bus_al.i_sync = 1'b0;
    tick(DB - 1);
    chk("al_pre", {bus_al.o_level, bus_al.o_rise}, 2'b00);
    tick(1);
    chk("al_rise", {bus_al.o_level, bus_al.o_rise}, 2'b11);
    tick(1);
    chk("al_post", {bus_al.o_level, bus_al.o_rise}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
